// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-sequencing controller for the KGP_MiniRISC core.
// Owns the architectural PC and runs a FETCH -> EXEC -> UPDATE loop. The
// branching_mechanism is combinational: in UPDATE it sees bm_pc/bm_branch_ctl
// and returns bm_target, which is committed as the next PC for taken branches.
// Optional feature macro: PC_SEQ_RETIRE_CNT_EN (retired-instruction counter).
module pc_sequencer #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [PC_WIDTH-1:0] PC_STEP  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stall,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr_out,
    output logic                instr_valid,
    input  logic                exec_done,
    input  logic                halt_req,
    input  logic [2:0]          branch_ctl_in,
    output logic [PC_WIDTH-1:0] bm_pc,
    output logic [2:0]          bm_branch_ctl,
    input  logic [PC_WIDTH-1:0] bm_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                running,
    output logic                halted,
    output logic [31:0]         retire_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [PC_WIDTH-1:0] pc_reg, pc_next;
    logic [31:0]         instr_reg, instr_next;
    logic                instr_valid_reg, instr_valid_next;
    logic [2:0]          bctl_reg, bctl_next;

    // State, PC, latched instruction and branch control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= RESET_PC;
            instr_reg       <= '0;
            instr_valid_reg <= 1'b0;
            bctl_reg        <= 3'b000;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            instr_reg       <= instr_next;
            instr_valid_reg <= instr_valid_next;
            bctl_reg        <= bctl_next;
        end
    end

    // Next-state and datapath updates; inputs are only looked at in their own state
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        instr_next       = instr_reg;
        instr_valid_next = 1'b0;
        bctl_next        = bctl_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                // An ack only counts while the request is actually asserted
                if (!stall && imem_ack) begin
                    instr_next       = imem_rdata;
                    instr_valid_next = 1'b1;
                    state_next       = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    // HALT wins over any branch type, so bm_branch_ctl stays clear
                    if (halt_req) begin
                        state_next = ST_HALTED;
                    end else begin
                        bctl_next  = branch_ctl_in;
                        state_next = ST_UPDATE;
                    end
                end
            end
            ST_UPDATE: begin
                // Target is taken as-is; sequential increment wraps modulo 2^PC_WIDTH
                pc_next    = (bctl_reg != 3'b000) ? bm_target : pc_reg + PC_STEP;
                bctl_next  = 3'b000;
                state_next = ST_FETCH;
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        imem_req      = (state_reg == ST_FETCH) && !stall;
        imem_addr     = pc_reg;
        bm_pc         = pc_reg;
        pc            = pc_reg;
        bm_branch_ctl = bctl_reg;
        instr_out     = instr_reg;
        instr_valid   = instr_valid_reg;
        running       = (state_reg == ST_FETCH) || (state_reg == ST_EXEC) ||
                        (state_reg == ST_UPDATE);
        halted        = (state_reg == ST_HALTED);
    end

`ifdef PC_SEQ_RETIRE_CNT_EN
    logic [31:0] retire_reg;
    logic        retire_inc;

    // Every UPDATE retires an instruction; a HALT retires on its way into HALTED
    assign retire_inc = (state_reg == ST_UPDATE) ||
                        ((state_reg == ST_EXEC) && exec_done && halt_req);

    // Retired-instruction counter, wraps at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_reg <= '0;
        end else if (retire_inc) begin
            retire_reg <= retire_reg + 32'd1;
        end
    end

    assign retire_count = retire_reg;
`else
    assign retire_count = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a table of instructions with their
// handshake timing and expected PCs, plus hand-written reset/halt sequences.
// Fetched words go into a scoreboard queue and are matched on instr_valid.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, stall, imem_ack, exec_done, halt_req;
    logic [31:0] imem_rdata, bm_target;
    logic [2:0]  branch_ctl_in;

    logic        imem_req, instr_valid, running, halted;
    logic [31:0] imem_addr, instr_out, bm_pc, pc, retire_count;
    logic [2:0]  bm_branch_ctl;

    logic        w_imem_req, w_instr_valid, w_running, w_halted;
    logic [31:0] w_imem_addr, w_instr_out, w_bm_pc, w_pc, w_retire_count;
    logic [2:0]  w_bm_branch_ctl;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb_q[$];
    logic        prev_valid = 1'b0;
    int unsigned exp_retire = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_valid(instr_valid),
        .exec_done(exec_done), .halt_req(halt_req), .branch_ctl_in(branch_ctl_in),
        .bm_pc(bm_pc), .bm_branch_ctl(bm_branch_ctl), .bm_target(bm_target),
        .pc(pc), .running(running), .halted(halted), .retire_count(retire_count)
    );

    // Second instance checks PC wrap from the top of the address space
    pc_sequencer #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_out(w_instr_out), .instr_valid(w_instr_valid),
        .exec_done(exec_done), .halt_req(halt_req), .branch_ctl_in(branch_ctl_in),
        .bm_pc(w_bm_pc), .bm_branch_ctl(w_bm_branch_ctl), .bm_target(bm_target),
        .pc(w_pc), .running(w_running), .halted(w_halted), .retire_count(w_retire_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_rc();
`ifdef PC_SEQ_RETIRE_CNT_EN
        return exp_retire;
`else
        return 32'd0;
`endif
    endfunction

    // Scoreboard monitor: every instr_valid must match a queued fetch word
    always @(negedge clk) begin
        if (instr_valid) begin
            if (sb_q.size() == 0) begin
                chk("spurious_instr_valid", {31'd0, instr_valid}, 32'd0);
            end else begin
                chk("instr_out", instr_out, sb_q.pop_front());
            end
            chk("instr_valid_not_double", {31'd0, prev_valid}, 32'd0);
        end
        prev_valid <= instr_valid;
    end

    typedef struct {
        logic [31:0] rdata;
        int          stall_n;
        int          ackwait_n;
        int          execwait_n;
        logic [2:0]  bctl;
        logic        halt;
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic [31:0] exp_next_pc;
    } vec_t;

    vec_t tbl[9];

    // Drive one instruction through FETCH/EXEC/UPDATE; DUT must be in FETCH on entry
    task automatic run_instr(input int idx);
        vec_t v;
        v = tbl[idx];
        chk($sformatf("running_%0d", idx), {31'd0, running}, 32'd1);
        chk($sformatf("pc_%0d", idx), pc, v.exp_pc);
        for (int i = 0; i < v.stall_n; i++) begin
            stall = 1'b1;
            imem_ack = 1'b1;              // ack while stalled must be ignored
            imem_rdata = 32'hDEAD_0000 + i;
            #1;
            chk($sformatf("req_stalled_%0d", idx), {31'd0, imem_req}, 32'd0);
            chk($sformatf("addr_stalled_%0d", idx), imem_addr, v.exp_pc);
            step();
        end
        stall = 1'b0;
        for (int i = 0; i < v.ackwait_n; i++) begin
            imem_ack = 1'b0;
            #1;
            chk($sformatf("req_wait_%0d", idx), {31'd0, imem_req}, 32'd1);
            chk($sformatf("addr_wait_%0d", idx), imem_addr, v.exp_pc);
            step();
        end
        imem_ack = 1'b1;
        imem_rdata = v.rdata;
        sb_q.push_back(v.rdata);
        #1;
        chk($sformatf("req_ack_%0d", idx), {31'd0, imem_req}, 32'd1);
        chk($sformatf("addr_ack_%0d", idx), imem_addr, v.exp_pc);
        step();
        imem_ack = 1'b0;
        imem_rdata = 32'h0BAD_BEEF;
        chk($sformatf("valid_pulse_%0d", idx), {31'd0, instr_valid}, 32'd1);
        for (int i = 0; i < v.execwait_n; i++) begin
            exec_done = 1'b0;
            halt_req = 1'b1;              // ignored without exec_done
            branch_ctl_in = 3'b101;
            step();
            chk($sformatf("exec_wait_%0d", idx), {29'd0, bm_branch_ctl}, 32'd0);
        end
        exec_done = 1'b1;
        halt_req = v.halt;
        branch_ctl_in = v.bctl;
        bm_target = v.target;
        step();
        exec_done = 1'b0;
        halt_req = 1'b0;
        branch_ctl_in = 3'b000;
        exp_retire++;
        if (v.halt) begin
            chk($sformatf("halted_%0d", idx), {30'd0, halted, running}, 32'd2);
            chk($sformatf("halt_pc_%0d", idx), pc, v.exp_next_pc);
            chk($sformatf("halt_bctl_%0d", idx), {29'd0, bm_branch_ctl}, 32'd0);
        end else begin
            chk($sformatf("upd_bctl_%0d", idx), {29'd0, bm_branch_ctl}, {29'd0, v.bctl});
            chk($sformatf("upd_bm_pc_%0d", idx), bm_pc, v.exp_pc);
            chk($sformatf("upd_req_%0d", idx), {31'd0, imem_req}, 32'd0);
            step();
            chk($sformatf("post_bctl_%0d", idx), {29'd0, bm_branch_ctl}, 32'd0);
            chk($sformatf("next_addr_%0d", idx), imem_addr, v.exp_next_pc);
        end
        chk($sformatf("retire_%0d", idx), retire_count, exp_rc());
    endtask

    initial begin
        //           rdata          stl ackw exw bctl    halt target        pc     next
        tbl[0] = '{32'hA000_0000, 0, 0, 0, 3'b000, 1'b0, 32'h0000_1234, 32'd0,  32'd1};
        tbl[1] = '{32'hA000_0001, 0, 0, 0, 3'b000, 1'b0, 32'd0,         32'd1,  32'd2};
        tbl[2] = '{32'hA000_0002, 0, 0, 0, 3'b000, 1'b0, 32'd0,         32'd2,  32'd3};
        tbl[3] = '{32'hB000_0003, 2, 1, 0, 3'b000, 1'b0, 32'd0,         32'd3,  32'd4};
        tbl[4] = '{32'hC000_0004, 0, 0, 1, 3'b001, 1'b0, 32'd2,         32'd4,  32'd2};
        tbl[5] = '{32'hC000_0005, 0, 0, 0, 3'b111, 1'b0, 32'd69,        32'd2,  32'd69};
        tbl[6] = '{32'hC000_0006, 0, 2, 0, 3'b100, 1'b0, 32'd4,         32'd69, 32'd4};
        tbl[7] = '{32'hD000_0007, 0, 0, 2, 3'b000, 1'b0, 32'd99,        32'd4,  32'd5};
        tbl[8] = '{32'hFFFF_0008, 0, 0, 0, 3'b010, 1'b1, 32'd77,        32'd5,  32'd5};

        rst = 1'b1; start = 1'b0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        exec_done = 1'b0; halt_req = 1'b0; branch_ctl_in = 3'b000; bm_target = '0;
        step();
        step();
        chk("rst_pc", pc, 32'd0);
        chk("rst_flags", {28'd0, imem_req, instr_valid, running, halted}, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_bctl", {29'd0, bm_branch_ctl}, 32'd0);
        chk("rst_retire", retire_count, 32'd0);
        chk("rst_pc_wrapinst", w_pc, 32'hFFFF_FFFF);
        rst = 1'b0;
        exp_retire = 0;
        step();
        step();
        chk("idle_hold", {31'd0, running}, 32'd0);

        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            run_instr(i);
            if (i == 0) chk("wrap_pc", w_pc, 32'd0);
        end

        // HALTED absorbs start, exec_done and imem_ack
        start = 1'b1; exec_done = 1'b1; imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_abs_flags", {30'd0, halted, imem_req}, 32'd2);
            chk("halt_abs_pc", pc, 32'd5);
            chk("halt_abs_bctl", {29'd0, bm_branch_ctl}, 32'd0);
        end
        start = 1'b0; exec_done = 1'b0; imem_ack = 1'b0;
        chk("halt_retire", retire_count, exp_rc());

        // Reset while in EXEC
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_retire = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        sb_q.push_back(32'h1111_2222);
        step();
        imem_ack = 1'b0;
        chk("exec_state", {31'd0, running}, 32'd1);
        exec_done = 1'b1; branch_ctl_in = 3'b011; rst = 1'b1;
        step();
        exec_done = 1'b0; branch_ctl_in = 3'b000;
        chk("rst_exec_pc", pc, 32'd0);
        chk("rst_exec_flags", {28'd0, imem_req, instr_valid, running, halted}, 32'd0);
        chk("rst_exec_bctl", {29'd0, bm_branch_ctl}, 32'd0);
        chk("rst_exec_instr", instr_out, 32'd0);

        // Reset in FETCH with ack pending, then a late ack
        rst = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk("fetch_pending_req", {31'd0, imem_req}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
        #1;
        chk("late_ack_req", {31'd0, imem_req}, 32'd0);
        step();
        step();
        imem_ack = 1'b0;
        chk("late_ack_flags", {28'd0, imem_req, instr_valid, running, halted}, 32'd0);
        chk("late_ack_instr", instr_out, 32'd0);
        chk("late_ack_retire", retire_count, 32'd0);
        step();
        chk("sb_drain", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
